sbox_server: RTL and testbench



---
 rtl/sbox_server_pkg.sv | 53 +++++
 rtl/sbox_server_gf_core.sv | 21 ++
 rtl/sbox_server.sv | 120 ++++++++++++
 tb/tb_sbox_server.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sbox_server_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the SBOX lookup responder.
// All arithmetic is modulo x^8+x^4+x^3+x+1.
package sbox_server_pkg;

    localparam logic [7:0] AES_POLY     = 8'h1B;
    localparam logic [7:0] AFFINE_C     = 8'h63;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end else begin
                p = p;
            end
            if (x[7]) begin
                x = {x[6:0], 1'b0} ^ AES_POLY;
            end else begin
                x = {x[6:0], 1'b0};
            end
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 for free.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ AFFINE_C;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ INV_AFFINE_C;
    endfunction

endpackage

// File: rtl/sbox_server_gf_core.sv
// Combinational S-box datapath: forward is GF inverse then affine,
// inverse mode is inverse affine then GF inverse.
module sbox_gf_core
    import sbox_server_pkg::*;
(
    input  logic [7:0] a,
    input  logic       inv_mode,
    output logic [7:0] y
);

    // Select substitution direction.
    always_comb begin
        y = 8'h00;
        if (inv_mode) begin
            y = gf_inv(affine_inv(a));
        end else begin
            y = affine_fwd(gf_inv(a));
        end
    end

endmodule

// File: rtl/sbox_server.sv
// SBOX lookup responder: one request per cycle, result registered one cycle later.
// The inverse table is filled from the forward datapath after reset when INIT_ON_RESET=1.
module sbox_server
    import sbox_server_pkg::*;
#(
    parameter bit INIT_ON_RESET = 1'b1,
    parameter bit ERR_ENABLE    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sbox_in,
    input  logic       sbox_en_de_in,
    input  logic       ce,
    input  logic       re,
    output logic [7:0] sbox_out,
    output logic       init_done,
    output logic       req_err
);

    logic [0:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_out;
    logic       r_init_done;
    logic       r_req_err;

    logic       w_req;
    logic       w_ready;
    logic       w_lookup_inv;
    logic [7:0] w_core_y;
    logic [7:0] w_inv_y;
    logic [7:0] w_result;

    assign w_req   = ce & re;
    assign w_ready = (r_state == ST_READY);

    sbox_gf_core u_lookup_core (
        .a        (sbox_in),
        .inv_mode (w_lookup_inv),
        .y        (w_core_y)
    );

    generate
        if (INIT_ON_RESET) begin : g_table
            logic [7:0] r_inv_tab [256];
            logic [7:0] w_fwd_cnt;

            assign w_lookup_inv = 1'b0;

            sbox_gf_core u_init_core (
                .a        (r_cnt),
                .inv_mode (1'b0),
                .y        (w_fwd_cnt)
            );

            // Table fill: entry fwd(cnt) holds cnt; contents are don't-care until READY.
            always_ff @(posedge clk) begin
                if (r_state == ST_INIT) begin
                    r_inv_tab[w_fwd_cnt] <= r_cnt;
                end
            end

            assign w_inv_y = r_inv_tab[sbox_in];
        end else begin : g_comb
            assign w_lookup_inv = ~sbox_en_de_in;
            assign w_inv_y      = w_core_y;
        end
    endgenerate

    assign w_result = sbox_en_de_in ? w_core_y : w_inv_y;

    // Init sequencer: 256 fill cycles, then READY until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= INIT_ON_RESET ? ST_INIT : ST_READY;
            r_cnt       <= 8'h00;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 8'h01;
                    if (r_cnt == 8'hFF) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_cnt       <= 8'h00;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    // Output and error registers; sbox_out holds when no request is made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= 8'h00;
            r_req_err <= 1'b0;
        end else begin
            r_req_err <= 1'b0;
            if (w_req) begin
                if (w_ready) begin
                    r_out <= w_result;
                end else begin
                    r_out     <= 8'h00;
                    r_req_err <= ERR_ENABLE;
                end
            end
        end
    end

    assign sbox_out  = r_out;
    assign init_done = r_init_done;
    assign req_err   = r_req_err;

endmodule

// File: tb/tb_sbox_server.sv
// Scoreboard bench for sbox_server: expected bytes come from an independent
// search-based GF model and are queued at drive time, popped after the edge.
module tb_sbox_server;

    logic       clk;
    logic       rst_n;
    logic [7:0] sbox_in;
    logic       sbox_en_de_in;
    logic       ce;
    logic       re;
    logic [7:0] sbox_out;
    logic       init_done;
    logic       req_err;

    int         n_vec;
    int         n_err;
    int         edge_cnt;
    logic [7:0] exp_out;
    logic [7:0] fwd_m [256];

    typedef struct packed {
        logic [7:0] out;
        logic       err;
    } exp_t;
    exp_t exp_q [$];

    sbox_server #(.INIT_ON_RESET(1'b1), .ERR_ENABLE(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sbox_in       (sbox_in),
        .sbox_en_de_in (sbox_en_de_in),
        .ce            (ce),
        .re            (re),
        .sbox_out      (sbox_out),
        .init_done     (init_done),
        .req_err       (req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Carry-less product followed by reduction with the 9-bit modulus 0x11B.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int j = 1; j < 256; j++)
            if (m_mul(x, 8'(j)) == 8'h01) r = 8'(j);
        return r;
    endfunction

    function automatic logic [7:0] m_affine(input logic [7:0] a);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8] ^ a[(i + 7) % 8] ^ c[i];
        return b;
    endfunction

    // One clock: drive inputs, queue the expectation, pop and compare after the edge.
    task automatic step(input logic c, input logic r, input logic [7:0] d, input logic ed,
                        input logic [7:0] exp_lookup);
        exp_t e;
        ce = c; re = r; sbox_in = d; sbox_en_de_in = ed;
        e.err = 1'b0;
        if (c && r) begin
            if (edge_cnt >= 256) begin
                exp_out = exp_lookup;
            end else begin
                exp_out = 8'h00;
                e.err   = 1'b1;
            end
        end
        e.out = exp_out;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        edge_cnt++;
        e = exp_q.pop_front();
        chk("sbox_out", sbox_out, e.out);
        chk("req_err", {7'h00, req_err}, {7'h00, e.err});
        chk("init_done", {7'h00, init_done}, {7'h00, (edge_cnt >= 256)});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        edge_cnt = 0;
        exp_out  = 8'h00;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_sbox_out", sbox_out, 8'h00);
        chk("rst_init_done", {7'h00, init_done}, 8'h00);
        chk("rst_req_err", {7'h00, req_err}, 8'h00);
        release_reset();
    endtask

    initial begin
        n_vec = 0; n_err = 0; edge_cnt = 0; exp_out = 8'h00;
        rst_n = 1'b0; ce = 1'b0; re = 1'b0; sbox_in = 8'h00; sbox_en_de_in = 1'b0;
        for (int x = 0; x < 256; x++) fwd_m[x] = m_affine(m_inv(8'(x)));

        #1;
        chk("rst_sbox_out", sbox_out, 8'h00);
        chk("rst_init_done", {7'h00, init_done}, 8'h00);
        chk("rst_req_err", {7'h00, req_err}, 8'h00);
        release_reset();

        // Early request at init cycle 10, then run to init_done at edge 256.
        idle(10);
        step(1'b1, 1'b1, 8'h53, 1'b1, 8'hED);
        idle(256 - 11);
        chk("init_at_256", {7'h00, init_done}, 8'h01);

        step(1'b1, 1'b1, 8'h00, 1'b1, 8'h63);
        step(1'b1, 1'b1, 8'h01, 1'b1, 8'h7C);
        step(1'b1, 1'b1, 8'h53, 1'b1, 8'hED);
        step(1'b1, 1'b1, 8'hFF, 1'b1, 8'h16);

        step(1'b1, 1'b1, 8'h63, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h7C, 1'b0, 8'h01);
        step(1'b1, 1'b1, 8'hED, 1'b0, 8'h53);
        step(1'b1, 1'b1, 8'h16, 1'b0, 8'hFF);

        for (int x = 0; x < 256; x++) begin
            step(1'b1, 1'b1, 8'(x), 1'b1, fwd_m[x]);
            step(1'b1, 1'b1, fwd_m[x], 1'b0, 8'(x));
        end

        step(1'b1, 1'b1, 8'h53, 1'b1, 8'hED);
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01, 1'b1, 8'h00);
        chk("hold_ed", sbox_out, 8'hED);

        step(1'b1, 1'b1, 8'h63, 1'b1, 8'hFB);
        step(1'b1, 1'b1, 8'h63, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h63, 1'b1, 8'hFB);
        step(1'b1, 1'b1, 8'h63, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h63, 1'b1, 8'hFB);

        // Async reset from READY, then again mid-INIT at cycle 100.
        async_reset();
        idle(100);
        async_reset();
        idle(256);
        chk("reinit_at_256", {7'h00, init_done}, 8'h01);
        step(1'b1, 1'b1, 8'hFF, 1'b1, 8'h16);
        step(1'b1, 1'b1, 8'h16, 1'b0, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
